// File: rtl/bcd_alu_pkg.sv
// Shared encodings for the BCD add/subtract unit: opcodes, FSM states and
// a digit-validity helper used when operands are captured.
package bcd_alu_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    // True when any of the four packed BCD digits is above 9.
    function automatic logic has_bad_digit(input logic [15:0] digits);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (digits[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/bcd_alu_digit_addsub.sv
// Single-digit BCD adder/subtractor with carry/borrow chaining.
// Add: s = a + b + cin, wraps above 9. Sub: d = a - b - cin, wraps below 0.
module bcd_digit_addsub (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       sub,
    output logic [3:0] d,
    output logic       cout
);

    logic [4:0] w_sum;
    logic [4:0] w_dif;

    // Operands are at most 9, so both results fit in 5 bits; w_dif[4] is the sign.
    assign w_sum = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    assign w_dif = {1'b0, a} - {1'b0, b} - {4'd0, cin};

    // Decimal correction: the low nibble arithmetic is mod 16, which makes
    // the +/-10 adjustment land on the right digit without wider math.
    always_comb begin
        d    = 4'd0;
        cout = 1'b0;
        if (sub) begin
            if (w_dif[4]) begin
                d    = w_dif[3:0] + 4'd10;
                cout = 1'b1;
            end else begin
                d    = w_dif[3:0];
            end
        end else begin
            if (w_sum > 5'd9) begin
                d    = w_sum[3:0] - 4'd10;
                cout = 1'b1;
            end else begin
                d    = w_sum[3:0];
            end
        end
    end

endmodule

// File: rtl/bcd_alu.sv
// 4-digit BCD add/subtract, one digit per clock, with in-place 10's
// complement pass so negative differences come out as a magnitude.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for start; operands captured on start
//   CALC    | digit-serial add/sub, index 0..3
//   FIX     | 10's complement of result after a final borrow, index 0..3
//   DONE    | set strobe for one cycle, then back to IDLE
module bcd_alu
    import bcd_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [3:0]  A1,
    input  logic [3:0]  A2,
    input  logic [3:0]  A3,
    input  logic [3:0]  A4,
    input  logic [3:0]  B1,
    input  logic [3:0]  B2,
    input  logic [3:0]  B3,
    input  logic [3:0]  B4,
    output logic [15:0] result,
    output logic        set,
    output logic        busy,
    output logic        ovf,
    output logic        neg,
    output logic        err
);

    alu_state_t  r_state;
    alu_state_t  w_state_nxt;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic        r_op;
    logic [1:0]  r_idx;
    logic        r_carry;
    logic [15:0] r_result;
    logic        r_set;
    logic        r_busy;
    logic        r_ovf;
    logic        r_neg;
    logic        r_err;
    logic        w_set_nxt;
    logic        w_busy_nxt;

    logic [15:0] w_a_in;
    logic [15:0] w_b_in;
    logic        w_bad_in;
    logic [3:0]  w_bit_ofs;
    logic [3:0]  w_dig_a;
    logic [3:0]  w_dig_b;
    logic        w_dig_sub;
    logic [3:0]  w_dig_d;
    logic        w_dig_cout;

    assign w_a_in    = {A4, A3, A2, A1};
    assign w_b_in    = {B4, B3, B2, B1};
    assign w_bad_in  = has_bad_digit(w_a_in) | has_bad_digit(w_b_in);
    assign w_bit_ofs = {r_idx, 2'b00};

    // Digit unit operand select: CALC uses the captured operands, FIX
    // subtracts the current result digit from zero.
    always_comb begin
        w_dig_a   = 4'd0;
        w_dig_b   = r_result[w_bit_ofs +: 4];
        w_dig_sub = 1'b1;
        if (r_state == ST_CALC) begin
            w_dig_a   = r_a[w_bit_ofs +: 4];
            w_dig_b   = r_b[w_bit_ofs +: 4];
            w_dig_sub = r_op;
        end
    end

    bcd_digit_addsub u_digit (
        .a    (w_dig_a),
        .b    (w_dig_b),
        .cin  (r_carry),
        .sub  (w_dig_sub),
        .d    (w_dig_d),
        .cout (w_dig_cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = w_bad_in ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = (r_op == OP_SUB && w_dig_cout) ? ST_FIX : ST_DONE;
                end
            end
            ST_FIX: begin
                if (r_idx == 2'd3) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the next state, registered below so set/busy line up
    // exactly with the state they describe.
    always_comb begin
        w_set_nxt  = (w_state_nxt == ST_DONE);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Strobe and busy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_set  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_set  <= w_set_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Datapath: operand capture, per-digit result writes and status flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a      <= 16'h0000;
            r_b      <= 16'h0000;
            r_op     <= OP_ADD;
            r_idx    <= 2'd0;
            r_carry  <= 1'b0;
            r_result <= 16'h0000;
            r_ovf    <= 1'b0;
            r_neg    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a      <= w_a_in;
                        r_b      <= w_b_in;
                        r_op     <= op;
                        r_idx    <= 2'd0;
                        r_carry  <= 1'b0;
                        r_result <= 16'h0000;
                        r_ovf    <= 1'b0;
                        r_neg    <= 1'b0;
                        r_err    <= w_bad_in;
                    end
                end
                ST_CALC: begin
                    r_result[w_bit_ofs +: 4] <= w_dig_d;
                    r_carry                  <= w_dig_cout;
                    r_idx                    <= r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        if (r_op == OP_ADD) begin
                            r_ovf <= w_dig_cout;
                        end else if (w_dig_cout) begin
                            r_neg   <= 1'b1;
                            r_carry <= 1'b0;
                        end
                    end
                end
                ST_FIX: begin
                    r_result[w_bit_ofs +: 4] <= w_dig_d;
                    r_carry                  <= w_dig_cout;
                    r_idx                    <= r_idx + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign set    = r_set;
    assign busy   = r_busy;
    assign ovf    = r_ovf;
    assign neg    = r_neg;
    assign err    = r_err;

endmodule

// File: tb/tb_bcd_alu.sv
// Directed bench for bcd_alu: hand-computed vectors, latency counted in
// clock edges where the edge that samples start is edge 1.
module tb_bcd_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [3:0]  A1, A2, A3, A4;
    logic [3:0]  B1, B2, B3, B4;
    logic [15:0] result;
    logic        set;
    logic        busy;
    logic        ovf;
    logic        neg;
    logic        err;

    int total;
    int bad;
    int lat;
    int set_seen;

    bcd_alu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A1     (A1),
        .A2     (A2),
        .A3     (A3),
        .A4     (A4),
        .B1     (B1),
        .B2     (B2),
        .B3     (B3),
        .B4     (B4),
        .result (result),
        .set    (set),
        .busy   (busy),
        .ovf    (ovf),
        .neg    (neg),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_operands(input logic [15:0] a, input logic [15:0] b, input logic o);
        {A4, A3, A2, A1} = a;
        {B4, B3, B2, B1} = b;
        op = o;
    endtask

    // Pulse start for one edge and count edges until set is seen (bounded).
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic o,
                         output int l);
        set_operands(a, b, o);
        start = 1'b1;
        tick();
        start = 1'b0;
        l = 1;
        while (!set && l < 20) begin
            tick();
            l++;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        start = 1'b0;
        set_operands(16'h0000, 16'h0000, 1'b0);

        // Reset state
        tick();
        tick();
        chk("reset_result", {16'h0, result}, 32'h0000_0000);
        chk("reset_ctrl", {27'h0, set, busy, ovf, neg, err}, 32'h0);
        rst = 1'b1;
        tick();

        // 1234 + 4321
        do_op(16'h1234, 16'h4321, 1'b0, lat);
        chk("add1_lat", lat, 5);
        chk("add1_res", {16'h0, result}, 32'h5555);
        chk("add1_flags", {29'h0, ovf, neg, err}, 32'h0);
        tick();
        chk("add1_idle", {30'h0, set, busy}, 32'h0);
        tick();
        chk("add1_hold", {16'h0, result}, 32'h5555);

        // 9999 + 0001 wraps with overflow
        do_op(16'h9999, 16'h0001, 1'b0, lat);
        chk("wrap_lat", lat, 5);
        chk("wrap_res", {16'h0, result}, 32'h0000);
        chk("wrap_flags", {29'h0, ovf, neg, err}, 32'h4);
        tick();

        // 0500 - 0123, no final borrow
        do_op(16'h0500, 16'h0123, 1'b1, lat);
        chk("sub1_lat", lat, 5);
        chk("sub1_res", {16'h0, result}, 32'h0377);
        chk("sub1_flags", {29'h0, ovf, neg, err}, 32'h0);
        tick();

        // 0123 - 0500, negative result via complement pass
        do_op(16'h0123, 16'h0500, 1'b1, lat);
        chk("sub2_lat", lat, 9);
        chk("sub2_res", {16'h0, result}, 32'h0377);
        chk("sub2_flags", {29'h0, ovf, neg, err}, 32'h2);
        tick();
        chk("sub2_idle", {31'h0, busy}, 32'h0);

        // 4242 - 4242
        do_op(16'h4242, 16'h4242, 1'b1, lat);
        chk("subeq_lat", lat, 5);
        chk("subeq_res", {16'h0, result}, 32'h0000);
        chk("subeq_flags", {29'h0, ovf, neg, err}, 32'h0);
        tick();

        // Start during CALC ignored; operands changed after start edge
        set_operands(16'h1234, 16'h1111, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        set_operands(16'h9999, 16'h9999, 1'b1);
        lat = 1;
        tick();
        lat++;
        start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        while (!set && lat < 20) begin
            tick();
            lat++;
        end
        chk("ign_lat", lat, 5);
        chk("ign_res", {16'h0, result}, 32'h2345);
        chk("ign_flags", {29'h0, ovf, neg, err}, 32'h0);
        tick();
        tick();
        chk("ign_noqueue", {30'h0, set, busy}, 32'h0);

        // Invalid digit
        do_op(16'h000A, 16'h0001, 1'b0, lat);
        chk("inv_lat", lat, 1);
        chk("inv_res", {16'h0, result}, 32'h0000);
        chk("inv_flags", {29'h0, ovf, neg, err}, 32'h1);
        tick();

        // Reset during CALC digit 2
        set_operands(16'h1234, 16'h4321, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid_res", {16'h0, result}, 32'h0000);
        chk("rst_mid_ctrl", {27'h0, set, busy, ovf, neg, err}, 32'h0);
        rst = 1'b1;
        set_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (set) set_seen++;
        end
        chk("rst_mid_noset", set_seen, 0);

        // Fresh operation after reset
        do_op(16'h0001, 16'h0002, 1'b0, lat);
        chk("post_rst_lat", lat, 5);
        chk("post_rst_res", {16'h0, result}, 32'h0003);
        chk("post_rst_flags", {29'h0, ovf, neg, err}, 32'h0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
